// File: rtl/al_accel_act_func_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : al_accel_act_func_pipe
//  Purpose  : Multi-lane, two-stage activation-function pipeline.
//             S1 evaluates RELU / RELU6 / hard-sigmoid / hard-tanh /
//             pass-through at DIN_W+2 bits. S2 saturates each lane to
//             DOUT_W bits and flags clamped lanes.
//             Valid/ready handshake, full throughput under backpressure.
//  Options  : ACT_FUNC_LEAKY_EN - when defined, function code 5 selects
//             leaky ReLU (x >>> 3 for negative x). Otherwise code 5 is
//             treated as pass-through.
//  Revision : 1.0 - initial release
// ============================================================================
module al_accel_act_func_pipe #(
   parameter int LANES  = 4,
   parameter int DIN_W  = 32,
   parameter int DOUT_W = 8,
   parameter int FRAC_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DIN_W-1:0]    in_data,
   input  logic [3:0]                in_typ,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DOUT_W-1:0]   out_data,
   output logic [LANES-1:0]          out_sat
);

   // Internal evaluation width: two guard bits above the input width.
   localparam int YW  = DIN_W + 2;
   localparam int ONE = 1 << FRAC_W;

   localparam logic signed [YW-1:0] ZERO_Y    = '0;
   localparam logic signed [YW-1:0] ONE_Y     = YW'(ONE);
   localparam logic signed [YW-1:0] NEG_ONE_Y = -ONE_Y;
   localparam logic signed [YW-1:0] HALF_Y    = YW'(ONE / 2);
   localparam logic signed [YW-1:0] SIX_Y     = YW'(6 * ONE);
   localparam logic signed [YW-1:0] MAX_Y     = YW'((1 << (DOUT_W - 1)) - 1);
   localparam logic signed [YW-1:0] MIN_Y     = ~MAX_Y;

   localparam logic [DOUT_W-1:0] MAX_O = {1'b0, {(DOUT_W-1){1'b1}}};
   localparam logic [DOUT_W-1:0] MIN_O = {1'b1, {(DOUT_W-1){1'b0}}};

   localparam logic [3:0] TYP_RELU    = 4'd0;
   localparam logic [3:0] TYP_RELU6   = 4'd1;
   localparam logic [3:0] TYP_SIGMOID = 4'd2;
   localparam logic [3:0] TYP_TANH    = 4'd3;
`ifdef ACT_FUNC_LEAKY_EN
   localparam logic [3:0] TYP_LEAKY   = 4'd5;
`endif

   logic                      s1_valid_q;
   logic                      s2_valid_q;
   logic [LANES*YW-1:0]       s1_y_q;
   logic [LANES*YW-1:0]       s1_y_d;
   logic [LANES*DOUT_W-1:0]   out_data_q;
   logic [LANES*DOUT_W-1:0]   out_data_d;
   logic [LANES-1:0]          out_sat_q;
   logic [LANES-1:0]          out_sat_d;
   logic                      s1_adv;
   logic                      s2_adv;

   // A stage may accept new contents when it is empty or its successor moves.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic signed [YW-1:0] x;
         logic signed [YW-1:0] sh2;
         logic signed [YW-1:0] y;
         logic signed [YW-1:0] yq;
         logic                 hi;
         logic                 lo;

         // Per-lane activation function, selected by the beat's function code.
         always_comb begin
            x   = YW'($signed(in_data[i*DIN_W +: DIN_W]));
            sh2 = (x >>> 2) + HALF_Y;
            y   = x;
            case (in_typ)
               TYP_RELU:    y = x[YW-1] ? ZERO_Y : x;
               TYP_RELU6:   y = x[YW-1] ? ZERO_Y : ((x > SIX_Y) ? SIX_Y : x);
               TYP_SIGMOID: y = sh2[YW-1] ? ZERO_Y : ((sh2 > ONE_Y) ? ONE_Y : sh2);
               TYP_TANH:    y = (x < NEG_ONE_Y) ? NEG_ONE_Y : ((x > ONE_Y) ? ONE_Y : x);
`ifdef ACT_FUNC_LEAKY_EN
               TYP_LEAKY:   y = x[YW-1] ? (x >>> 3) : x;
`endif
               default:     y = x;
            endcase
         end

         assign s1_y_d[i*YW +: YW] = y;

         // Saturation of the stage-1 result to the output width.
         assign yq = s1_y_q[i*YW +: YW];
         assign hi = (yq > MAX_Y);
         assign lo = (yq < MIN_Y);
         assign out_data_d[i*DOUT_W +: DOUT_W] = hi ? MAX_O : (lo ? MIN_O : yq[DOUT_W-1:0]);
         assign out_sat_d[i] = hi | lo;
      end : g_lane
   endgenerate

   // Stage 1: capture the evaluated function result of an accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_y_q     <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_y_q <= s1_y_d;
         end
      end
   end

   // Stage 2: saturated output register, held stable while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_al_accel_act_func_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_al_accel_act_func_pipe
//  Purpose  : Self-checking bench for al_accel_act_func_pipe: fixed vectors,
//             backpressure and mid-stream reset sequences, and randomized
//             traffic against a behavioural reference model.
//  Options  : ACT_FUNC_LEAKY_EN selects the leaky-ReLU expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_al_accel_act_func_pipe;

   localparam int LANES  = 4;
   localparam int DIN_W  = 32;
   localparam int DOUT_W = 8;
   localparam int FRAC_W = 4;
   localparam int ONE    = 1 << FRAC_W;
   localparam int NV     = 9;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*DIN_W-1:0]   in_data;
   logic [3:0]               in_typ;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*DOUT_W-1:0]  out_data;
   logic [LANES-1:0]         out_sat;

   al_accel_act_func_pipe #(
      .LANES  (LANES),
      .DIN_W  (DIN_W),
      .DOUT_W (DOUT_W),
      .FRAC_W (FRAC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_typ    (in_typ),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] din;
      logic [3:0]   typ;
      logic [31:0]  dexp;
      logic [3:0]   sexp;
   } vec_t;

   vec_t         vt[NV];
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [35:0]  sbq[$];
   int           out_log[$];
   logic         prev_stall = 1'b0;
   logic [35:0]  prev_out   = '0;
   int           acc_cnt    = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [127:0] pk_in(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [31:0] pk_out(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // Floor division for a positive divisor.
   function automatic longint fdiv(input longint x, input longint d);
      longint q;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint act_ref(input longint x, input int typ);
      longint y;
      case (typ)
         0:       y = (x > 0) ? x : 0;
         1:       y = (x < 0) ? 0 : ((x > 6*ONE) ? 6*ONE : x);
         2: begin
                  y = fdiv(x, 4) + ONE/2;
                  if (y < 0)   y = 0;
                  if (y > ONE) y = ONE;
            end
         3:       y = (x < -ONE) ? -ONE : ((x > ONE) ? ONE : x);
`ifdef ACT_FUNC_LEAKY_EN
         5:       y = (x >= 0) ? x : fdiv(x, 8);
`endif
         default: y = x;
      endcase
      return y;
   endfunction

   // Expected {sat, data} of one beat.
   function automatic logic [35:0] model(input logic [127:0] din, input logic [3:0] typ);
      logic [31:0] d;
      logic [3:0]  s;
      longint      x, y;
      longint      hi, lo;
      hi = (64'sd1 <<< (DOUT_W-1)) - 1;
      lo = -(64'sd1 <<< (DOUT_W-1));
      for (int i = 0; i < LANES; i++) begin
         x = longint'($signed(din[i*DIN_W +: DIN_W]));
         y = act_ref(x, int'(typ));
         s[i] = (y > hi) || (y < lo);
         if (y > hi) y = hi;
         if (y < lo) y = lo;
         d[i*DOUT_W +: DOUT_W] = DOUT_W'(y);
      end
      return {s, d};
   endfunction

   // One clock: bookkeeping at the falling edge, inputs may change #1 after the rising edge.
   task automatic cycle();
      logic [35:0] e;
      @(negedge clk);
      if (rst_n) begin
         chk("in_ready", in_ready, !(sbq.size() == 2 && !out_ready));
         if (prev_stall) chk("stall hold", {out_valid, out_sat, out_data}, {1'b1, prev_out});
      end
      if (out_valid && out_ready) begin
         out_log.push_back(int'($signed(out_data[DOUT_W-1:0])));
         if (sbq.size() == 0) begin
            chk("unexpected output", 1'b1, 1'b0);
         end else begin
            e = sbq.pop_front();
            chk("scoreboard", {out_sat, out_data}, e);
         end
      end
      if (rst_n && in_valid && in_ready) begin
         sbq.push_back(model(in_data, in_typ));
         acc_cnt++;
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_out   = {out_sat, out_data};
      if (!rst_n) sbq.delete();
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd_lane();
      int pick[12] = '{127, 128, -128, -129, 96, 97, 16, 17, -16, -17, 0, -1};
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 600)) - 300;
         1:       return int'($urandom);
         2:       return int'($urandom_range(0, 80)) - 40;
         default: return pick[$urandom_range(0, 11)];
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{"relu",     pk_in(-5, 37, 200, -1),        4'd0, pk_out(0, 37, 127, 0),      4'b0100};
      vt[1] = '{"relu6",    pk_in(-5, 37, 200, -1),        4'd1, pk_out(0, 37, 96, 0),       4'b0000};
      vt[2] = '{"sigmoid",  pk_in(0, 32, -64, -3),         4'd2, pk_out(8, 16, 0, 7),        4'b0000};
      vt[3] = '{"tanh_a",   pk_in(0, 32, -64, -3),         4'd3, pk_out(0, 16, -16, -3),     4'b0000};
      vt[4] = '{"tanh_b",   pk_in(40, -40, 5, 16),         4'd3, pk_out(16, -16, 5, 16),     4'b0000};
      vt[5] = '{"nofunc",   pk_in(1000, -1000, 127, -128), 4'd4, pk_out(127, -128, 127, -128), 4'b0011};
      vt[6] = '{"code9",    pk_in(1000, -1000, 127, -128), 4'd9, pk_out(127, -128, 127, -128), 4'b0011};
      vt[7] = '{"code15",   pk_in(1000, -1000, 127, -128), 4'd15, pk_out(127, -128, 127, -128), 4'b0011};
`ifdef ACT_FUNC_LEAKY_EN
      vt[8] = '{"leaky",    pk_in(-64, 20, -7, -2000),     4'd5, pk_out(-8, 20, -1, -128),   4'b1000};
`else
      vt[8] = '{"code5",    pk_in(-64, 20, -7, -2000),     4'd5, pk_out(-64, 20, -7, -128),  4'b1000};
`endif

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_typ = '0; out_ready = 1'b1;
      repeat (3) cycle();
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_data",  out_data,  '0);
      chk("reset out_sat",   out_sat,   '0);
      rst_n = 1'b1;
      cycle();

      // Fixed vectors: result appears exactly two cycles after acceptance.
      for (int k = 0; k < NV; k++) begin
         in_data = vt[k].din; in_typ = vt[k].typ; in_valid = 1'b1;
         cycle();
         in_valid = 1'b0;
         chk({vt[k].name, " not yet valid"}, out_valid, 1'b0);
         cycle();
         chk({vt[k].name, " valid"}, out_valid, 1'b1);
         chk({vt[k].name, " data"},  out_data,  vt[k].dexp);
         chk({vt[k].name, " sat"},   out_sat,   vt[k].sexp);
         cycle();
      end

      // Backpressure: 8 beats, out_ready low for 3 cycles mid-stream.
      begin
         int base;
         base = acc_cnt;
         out_log.delete();
         for (int c = 0; c < 40 && out_log.size() < 8; c++) begin
            in_valid  = (acc_cnt - base) < 8;
            in_data   = pk_in(acc_cnt - base + 1, 3, -3, 500);
            in_typ    = 4'd4;
            out_ready = !(c >= 3 && c < 6);
            if (c >= 6) chk("bp throughput", out_valid, 1'b1);
            cycle();
         end
         in_valid = 1'b0; out_ready = 1'b1;
         chk("bp count", out_log.size(), 8);
         for (int i = 0; i < 8 && i < out_log.size(); i++) chk("bp order", out_log[i], i + 1);
      end

      // Reset with two beats in flight.
      in_typ = 4'd4; in_valid = 1'b1;
      in_data = pk_in(11, 0, 0, 0); cycle();
      in_data = pk_in(22, 0, 0, 0); cycle();
      in_valid = 1'b0; rst_n = 1'b0; cycle();
      rst_n = 1'b1;
      chk("midrst out_valid", out_valid, 1'b0);
      chk("midrst out_data",  out_data,  '0);
      chk("midrst out_sat",   out_sat,   '0);
      in_data = pk_in(-5, 37, 200, -1); in_typ = 4'd1; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("postrst not yet valid", out_valid, 1'b0);
      cycle();
      chk("postrst valid", out_valid, 1'b1);
      chk("postrst data",  out_data,  pk_out(0, 37, 96, 0));
      cycle();

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_typ    = 4'($urandom_range(0, 15));
         in_data   = pk_in(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
         out_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && sbq.size() > 0; c++) cycle();
      chk("drain empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
